// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - instruction fetch/decode/execute control sequencer
// Optional MOC watchdog: define CONTROL_SEQUENCER_MOC_TIMEOUT_EN.
module control_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IR_OUT,
  input  logic        MOC,
  input  logic        CONDTESTER_OUT,
  input  logic        LSM_DETECT,
  input  logic        LSM_END,
  output logic [33:0] cu_datapath,
  output logic [4:0]  STATE,
  output logic        FAULT
);

  localparam logic [4:0] S_RST      = 5'd0;
  localparam logic [4:0] S_F1       = 5'd1;
  localparam logic [4:0] S_F2       = 5'd2;
  localparam logic [4:0] S_F3       = 5'd3;
  localparam logic [4:0] S_DEC      = 5'd4;
  localparam logic [4:0] S_DP       = 5'd5;
  localparam logic [4:0] S_LS_ADDR  = 5'd6;
  localparam logic [4:0] S_LD_WAIT  = 5'd7;
  localparam logic [4:0] S_LD_WB    = 5'd8;
  localparam logic [4:0] S_ST_MDR   = 5'd9;
  localparam logic [4:0] S_ST_WAIT  = 5'd10;
  localparam logic [4:0] S_LSM_INIT = 5'd11;
  localparam logic [4:0] S_LSM_STEP = 5'd12;
  localparam logic [4:0] S_LSM_WAIT = 5'd13;
  localparam logic [4:0] S_BR       = 5'd14;

  localparam logic [4:0] ALU_PASS_A = 5'b10000;
  localparam logic [4:0] ALU_INC4   = 5'b10010;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  logic [4:0] state;
  logic [4:0] next_state;
  logic       link_flag;
  logic       timeout;

  logic       flag_sel, rf_ld, ir_ld, mar_ld, mdr_ld, rw, mfa, me_sel, sls_en, lsm_ld, mf_sel;
  logic [1:0] ma_sel, md_sel, mh_sel;
  logic [2:0] mc_sel, dsize;
  logic [4:0] alu_op;

  logic unused_ir_bits;
  assign unused_ir_bits = &{1'b0, IR_OUT[31:28], IR_OUT[23:21], IR_OUT[19:0]};

`ifdef CONTROL_SEQUENCER_MOC_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       in_wait;

  assign in_wait = (state == S_F3) || (state == S_LD_WAIT) ||
                   (state == S_ST_WAIT) || (state == S_LSM_WAIT);
  assign timeout = in_wait && (wait_cnt == 4'hF) && !MOC;

  // Counter restarts whenever the state changes, so it only runs while a wait state self-loops.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wait_cnt <= 4'd0;
    end else if (next_state != state) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign FAULT = timeout;
  assign STATE = state;

  always_comb begin
    next_state = S_RST;
    case (state)
      S_RST:      next_state = S_F1;
      S_F1:       next_state = S_F2;
      S_F2:       next_state = S_F3;
      S_F3:       next_state = MOC ? S_DEC : S_F3;
      S_DEC: begin
        if (!CONDTESTER_OUT)            next_state = S_F1;
        else if (IR_OUT[27:26] == 2'b00) next_state = S_DP;
        else if (IR_OUT[27:26] == 2'b01) next_state = S_LS_ADDR;
        else if (IR_OUT[27:25] == 3'b100) next_state = S_LSM_INIT;
        else if (IR_OUT[27:25] == 3'b101) next_state = S_BR;
        else                             next_state = S_F1;
      end
      S_DP:       next_state = S_F1;
      S_LS_ADDR:  next_state = IR_OUT[20] ? S_LD_WAIT : S_ST_MDR;
      S_LD_WAIT:  next_state = MOC ? S_LD_WB : S_LD_WAIT;
      S_LD_WB:    next_state = S_F1;
      S_ST_MDR:   next_state = S_ST_WAIT;
      S_ST_WAIT:  next_state = MOC ? S_F1 : S_ST_WAIT;
      S_LSM_INIT: next_state = LSM_DETECT ? S_LSM_STEP : S_F1;
      S_LSM_STEP: next_state = S_LSM_WAIT;
      S_LSM_WAIT: next_state = MOC ? (LSM_END ? S_F1 : S_LSM_STEP) : S_LSM_WAIT;
      S_BR:       next_state = S_F1;
      default:    next_state = S_RST;
    endcase
    if (timeout) next_state = S_F1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= S_RST;
      link_flag <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_BR)      link_flag <= IR_OUT[24];
      else if (state == S_F1) link_flag <= 1'b0;
    end
  end

  // Fields come from the state register; only the MOC-qualified load strobes look at MOC.
  always_comb begin
    flag_sel = 1'b0; rf_ld = 1'b0; ir_ld = 1'b0; mar_ld = 1'b0; mdr_ld = 1'b0;
    rw = 1'b0; mfa = 1'b0; me_sel = 1'b0; sls_en = 1'b0; lsm_ld = 1'b0; mf_sel = 1'b0;
    ma_sel = 2'b00; md_sel = 2'b00; mh_sel = 2'b00;
    mc_sel = 3'b000; dsize = 3'b000; alu_op = 5'b00000;
    case (state)
      S_F1: begin
        ma_sel = 2'b01; alu_op = ALU_PASS_A; mar_ld = 1'b1;
        if (link_flag) begin
          mc_sel = 3'b010; rf_ld = 1'b1;
        end
      end
      S_F2: begin
        ma_sel = 2'b01; alu_op = ALU_INC4; mc_sel = 3'b001; rf_ld = 1'b1;
        mfa = 1'b1; rw = 1'b1; dsize = SIZE_WORD;
      end
      S_F3: begin
        mfa = 1'b1; rw = 1'b1; ir_ld = MOC;
      end
      S_DP: begin
        md_sel = 2'b01; mc_sel = 3'b011; rf_ld = 1'b1; flag_sel = 1'b1;
      end
      S_LS_ADDR: begin
        md_sel = 2'b10; mar_ld = 1'b1;
      end
      S_LD_WAIT: begin
        mfa = 1'b1; mh_sel = 2'b01; mf_sel = 1'b1; sls_en = 1'b1; me_sel = 1'b1; mdr_ld = MOC;
      end
      S_LD_WB: begin
        alu_op = ALU_PASS_A; mc_sel = 3'b011; rf_ld = 1'b1;
      end
      S_ST_MDR: begin
        ma_sel = 2'b11; alu_op = ALU_PASS_A; mdr_ld = 1'b1;
      end
      S_ST_WAIT: begin
        mfa = 1'b1; sls_en = 1'b1;
      end
      S_LSM_INIT: begin
        lsm_ld = 1'b1; mar_ld = 1'b1;
      end
      S_LSM_STEP: begin
        mfa = 1'b1; mh_sel = 2'b10;
      end
      S_LSM_WAIT: begin
        if (MOC && IR_OUT[20]) begin
          mc_sel = 3'b100; rf_ld = 1'b1;
        end
      end
      S_BR: begin
        mc_sel = 3'b001; rf_ld = 1'b1;
      end
      default: ;
    endcase
    cu_datapath = {flag_sel, rf_ld, ir_ld, mar_ld, mdr_ld, rw, mfa, ma_sel, 3'b000,
                   mc_sel, md_sel, me_sel, alu_op, sls_en, dsize, lsm_ld, 3'b000,
                   mh_sel, mf_sel};
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
// Set CONTROL_SEQUENCER_MOC_TIMEOUT_EN to exercise the MOC watchdog.
module tb_control_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IR_OUT;
  logic        MOC, CONDTESTER_OUT, LSM_DETECT, LSM_END;
  logic [33:0] cu_datapath;
  logic [4:0]  STATE;
  logic        FAULT;

  int n_checks = 0;
  int n_fail = 0;

  control_sequencer dut (
    .CLK(CLK), .RESET(RESET), .IR_OUT(IR_OUT), .MOC(MOC),
    .CONDTESTER_OUT(CONDTESTER_OUT), .LSM_DETECT(LSM_DETECT), .LSM_END(LSM_END),
    .cu_datapath(cu_datapath), .STATE(STATE), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  // State numbering follows the order the states are listed in
  localparam int RST = 0, F1 = 1, F2 = 2, F3 = 3, DEC = 4, DP = 5, LS_ADDR = 6,
                 LD_WAIT = 7, LD_WB = 8, ST_MDR = 9, ST_WAIT = 10, LSM_INIT = 11,
                 LSM_STEP = 12, LSM_WAIT = 13, BR = 14;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: control word assembled from named field values
  function automatic logic [33:0] exp_word(input int st, input logic moc,
                                           input logic [31:0] ir, input logic link);
    int ma = 0, md = 0, mc = 0, mh = 0, alu = 0, sz = 0;
    int flag = 0, rf = 0, irl = 0, mar = 0, mdr = 0, rw = 0, mfa = 0;
    int me = 0, sls = 0, lsml = 0, mf = 0;
    logic [33:0] w;
    case (st)
      F1:       begin ma = 1; alu = 16; mar = 1; if (link) begin mc = 2; rf = 1; end end
      F2:       begin ma = 1; alu = 18; mc = 1; rf = 1; mfa = 1; rw = 1; sz = 2; end
      F3:       begin mfa = 1; rw = 1; irl = moc ? 1 : 0; end
      DP:       begin md = 1; mc = 3; rf = 1; flag = 1; end
      LS_ADDR:  begin md = 2; mar = 1; end
      LD_WAIT:  begin mfa = 1; mh = 1; mf = 1; sls = 1; me = 1; mdr = moc ? 1 : 0; end
      LD_WB:    begin alu = 16; mc = 3; rf = 1; end
      ST_MDR:   begin ma = 3; alu = 16; mdr = 1; end
      ST_WAIT:  begin mfa = 1; sls = 1; end
      LSM_INIT: begin lsml = 1; mar = 1; end
      LSM_STEP: begin mfa = 1; mh = 2; end
      LSM_WAIT: if (moc && ir[20]) begin mc = 4; rf = 1; end
      BR:       begin mc = 1; rf = 1; end
      default:  ;
    endcase
    w = 34'(flag) * (34'd1 << 33) + 34'(rf) * (34'd1 << 32) + 34'(irl) * (34'd1 << 31)
      + 34'(mar) * (34'd1 << 30) + 34'(mdr) * (34'd1 << 29) + 34'(rw) * (34'd1 << 28)
      + 34'(mfa) * (34'd1 << 27) + 34'(ma) * (34'd1 << 25) + 34'(mc) * (34'd1 << 19)
      + 34'(md) * (34'd1 << 17) + 34'(me) * (34'd1 << 16) + 34'(alu) * (34'd1 << 11)
      + 34'(sls) * (34'd1 << 10) + 34'(sz) * (34'd1 << 7) + 34'(lsml) * (34'd1 << 6)
      + 34'(mh) * (34'd1 << 1) + 34'(mf);
    return w;
  endfunction

  function automatic int model_next(input int st, input logic moc, input logic cond,
                                    input logic [31:0] ir, input logic det, input logic lend);
    logic [31:0] v;
    v = ir;
    case (st)
      RST: return F1;
      F1: return F2;
      F2: return F3;
      F3: return moc ? DEC : F3;
      DEC: begin
        if (!cond) return F1;
        case (v[27:25])
          3'b000, 3'b001: return DP;
          3'b010, 3'b011: return LS_ADDR;
          3'b100: return LSM_INIT;
          3'b101: return BR;
          default: return F1;
        endcase
      end
      DP, LD_WB, BR: return F1;
      LS_ADDR: return v[20] ? LD_WAIT : ST_MDR;
      LD_WAIT: return moc ? LD_WB : LD_WAIT;
      ST_MDR: return ST_WAIT;
      ST_WAIT: return moc ? F1 : ST_WAIT;
      LSM_INIT: return det ? LSM_STEP : F1;
      LSM_STEP: return LSM_WAIT;
      LSM_WAIT: return moc ? (lend ? F1 : LSM_STEP) : LSM_WAIT;
      default: return RST;
    endcase
  endfunction

  int   m_state = 0;
  int   m_wait = 0;
  logic m_link = 1'b0;
  bit   started = 1'b0;

  function automatic logic model_fault(input int st, input int cycles_before, input logic moc);
`ifdef CONTROL_SEQUENCER_MOC_TIMEOUT_EN
    return (st == F3 || st == LD_WAIT || st == ST_WAIT || st == LSM_WAIT)
           && cycles_before == 15 && !moc;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge CLK) begin
    int nxt;
    started = 1'b1;
    if (!RESET) begin
      m_state = RST; m_link = 1'b0; m_wait = 0;
    end else begin
      nxt = model_next(m_state, MOC, CONDTESTER_OUT, IR_OUT, LSM_DETECT, LSM_END);
      if (model_fault(m_state, m_wait, MOC)) nxt = F1;
      if (m_state == BR) m_link = IR_OUT[24];
      else if (m_state == F1) m_link = 1'b0;
      m_wait = (nxt == m_state) ? m_wait + 1 : 0;
      m_state = nxt;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      check("model_state", 64'(STATE), 64'(m_state));
      check("model_word", 64'(cu_datapath), 64'(exp_word(m_state, MOC, IR_OUT, m_link)));
      check("model_fault", 64'(FAULT), 64'(model_fault(m_state, m_wait, MOC)));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; IR_OUT = 32'h0; MOC = 1'b0; CONDTESTER_OUT = 1'b0;
    LSM_DETECT = 1'b0; LSM_END = 1'b0;
    repeat (3) tick();
    check("reset_state", 64'(STATE), 64'd0);
    check("reset_word", 64'(cu_datapath), 64'd0);
    check("reset_fault", 64'(FAULT), 64'd0);

    // Fetch with MOC tied high, then ADD R0,R1,R2
    RESET = 1'b1; MOC = 1'b1; IR_OUT = 32'hE0810002; CONDTESTER_OUT = 1'b1;
    tick(); check("seq_f1", 64'(STATE), 64'd1);
    check("f1_word", 64'(cu_datapath), 64'h0_4200_8000);
    tick(); check("seq_f2", 64'(STATE), 64'd2);
    tick(); check("seq_f3", 64'(STATE), 64'd3);
    check("f3_ir_load", 64'(cu_datapath[31]), 64'd1);
    check("f3_word", 64'(cu_datapath), 64'h0_9800_0000);
    tick(); check("seq_dec", 64'(STATE), 64'd4);
    check("dec_word", 64'(cu_datapath), 64'd0);
    tick(); check("dp_state", 64'(STATE), 64'd5);
    check("dp_word", 64'(cu_datapath), 64'h3_001A_0000);
    tick(); check("dp_to_f1", 64'(STATE), 64'd1);

    // F3 held by MOC low
    MOC = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("f3_hold_state", 64'(STATE), 64'd3);
      check("f3_hold_irld", 64'(cu_datapath[31]), 64'd0);
      tick();
    end
    check("f3_hold_state", 64'(STATE), 64'd3);
    MOC = 1'b1;
    #1 check("f3_moc_irld", 64'(cu_datapath[31]), 64'd1);

    // Condition fails in DEC
    CONDTESTER_OUT = 1'b0; IR_OUT = 32'h01234567;
    tick(); check("cond_dec", 64'(STATE), 64'd4);
    tick(); check("cond_f1", 64'(STATE), 64'd1);
    check("cond_no_rf", 64'(cu_datapath[32]), 64'd0);

    // Load, reset in the middle of LD_WAIT
    IR_OUT = 32'hE5910000; CONDTESTER_OUT = 1'b1;
    repeat (4) tick();
    check("ld_addr", 64'(STATE), 64'd6);
    tick(); check("ld_wait", 64'(STATE), 64'd7);
    MOC = 1'b0;
    tick(); check("ld_wait_hold", 64'(STATE), 64'd7);
    RESET = 1'b0;
    tick(); check("ld_rst_state", 64'(STATE), 64'd0);
    check("ld_rst_word", 64'(cu_datapath), 64'd0);
    RESET = 1'b1; MOC = 1'b1;
    tick(); check("rst_to_f1", 64'(STATE), 64'd1);

    // Store with MOC held low in ST_WAIT
    IR_OUT = 32'hE5810000;
    repeat (5) tick();
    check("st_mdr", 64'(STATE), 64'd9);
    MOC = 1'b0;
    tick();
`ifdef CONTROL_SEQUENCER_MOC_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      check("st_wait_hold", 64'(STATE), 64'd10);
      check("st_no_fault", 64'(FAULT), 64'd0);
      tick();
    end
    check("st_wait_16", 64'(STATE), 64'd10);
    check("st_fault_16", 64'(FAULT), 64'd1);
    tick(); check("st_fault_f1", 64'(STATE), 64'd1);
    check("st_fault_clr", 64'(FAULT), 64'd0);
    MOC = 1'b1;
`else
    for (int k = 1; k <= 20; k++) begin
      check("st_wait_hold", 64'(STATE), 64'd10);
      check("st_no_fault", 64'(FAULT), 64'd0);
      tick();
    end
    MOC = 1'b1;
    tick(); check("st_done_f1", 64'(STATE), 64'd1);
`endif

    // Load-multiple with two register steps
    IR_OUT = 32'hE8900006; LSM_DETECT = 1'b1; LSM_END = 1'b0;
    repeat (4) tick();
    check("lsm_init", 64'(STATE), 64'd11);
    tick(); check("lsm_step", 64'(STATE), 64'd12);
    tick(); check("lsm_wait", 64'(STATE), 64'd13);
    check("lsm_wait_word", 64'(cu_datapath), 64'h1_0020_0000);
    tick(); check("lsm_step2", 64'(STATE), 64'd12);
    LSM_END = 1'b1;
    tick(); check("lsm_wait2", 64'(STATE), 64'd13);
    tick(); check("lsm_done", 64'(STATE), 64'd1);

    // LSM without a register list
    LSM_DETECT = 1'b0;
    repeat (4) tick();
    check("lsm_init_nodet", 64'(STATE), 64'd11);
    tick(); check("lsm_nodet_f1", 64'(STATE), 64'd1);

    // Branch with link, then an undecoded class
    IR_OUT = 32'hEB000000;
    repeat (4) tick();
    check("br_state", 64'(STATE), 64'd14);
    check("br_word", 64'(cu_datapath), 64'h1_0008_0000);
    tick(); check("bl_f1", 64'(STATE), 64'd1);
    check("bl_f1_word", 64'(cu_datapath), 64'h1_4210_8000);
    IR_OUT = 32'hEC000000;
    repeat (4) tick();
    check("other_f1", 64'(STATE), 64'd1);
    check("other_f1_word", 64'(cu_datapath), 64'h0_4200_8000);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
